// File: rtl/feeder_pkg.sv
// Shared definitions for the operand feeder: state encoding, parameter
// defaults and the counter-width helper used to size the shared timer.
package feeder_pkg;

  localparam int SETUP_CYCLES_DEF = 2;
  localparam int PRESS_CYCLES_DEF = 2;
  localparam int RESULT_WAIT_DEF  = 4;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_SETUP_A  = 4'd1,
    ST_PRESS_A  = 4'd2,
    ST_REL_A    = 4'd3,
    ST_SETUP_B  = 4'd4,
    ST_PRESS_B  = 4'd5,
    ST_REL_B    = 4'd6,
    ST_WAIT_RES = 4'd7,
    ST_DONE     = 4'd8
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold max_val without wrapping (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/feeder_timer.sv
// Load / decrement down-counter shared by all timed feeder states.
// Decrement saturates at zero so the count can never wrap.
module feeder_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);
  assign last = (count == ONE);

endmodule

// File: rtl/operand_feeder.sv
// Operand feeder: presents two latched operands, one at a time, to an
// arithmetic unit using a setup / press / release strobe sequence, then
// waits a bounded time for the result and reports it with a Done pulse.
//
// Handshake: Start is a request strobe with no ready; it is accepted only
// when the FSM is in IDLE and ignored everywhere else (Busy high or the
// DONE cycle). ResultValid is only honoured in WAIT_RES. Go and DataOut
// are registered so the arithmetic unit never sees a combinational path.
module operand_feeder
  import feeder_pkg::*;
#(
  parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int PRESS_CYCLES = PRESS_CYCLES_DEF,
  parameter int RESULT_WAIT  = RESULT_WAIT_DEF
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic [7:0] OpA,
  input  logic [7:0] OpB,
  output logic       Go,
  output logic [7:0] DataOut,
  input  logic [7:0] DataResult,
  input  logic       ResultValid,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Result,
  output logic       Timeout,
  output logic [3:0] state_dbg
);

  localparam int CNT_MAX = max3(SETUP_CYCLES, PRESS_CYCLES, RESULT_WAIT);
  localparam int CW      = cnt_width(CNT_MAX);

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES);
  localparam logic [CW-1:0] PRESS_LD = CW'(PRESS_CYCLES);
  localparam logic [CW-1:0] WAIT_LD  = CW'(RESULT_WAIT);

  state_t          state, next_state;
  logic [7:0]      op_a, op_b;
  logic            latch_ops;
  logic            capture, capture_to;
  logic            tmr_load, tmr_dec, tmr_zero, tmr_last, expire;
  logic [CW-1:0]   tmr_load_val;
  logic            go_d, busy_d, done_d;
  logic [7:0]      data_d;

  assign state_dbg = state;
  // Zero is only reachable if a parameter is misconfigured below 1.
  assign expire    = tmr_last | tmr_zero;

  feeder_timer #(.WIDTH(CW)) u_timer (
    .clk      (Clock),
    .resetn   (Resetn),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero),
    .last     (tmr_last)
  );

  // Next-state and timer control: each timed state lasts exactly the loaded count.
  always_comb begin
    next_state   = state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    latch_ops    = 1'b0;
    capture      = 1'b0;
    capture_to   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          latch_ops    = 1'b1;
          tmr_load     = 1'b1;
          tmr_load_val = SETUP_LD;
          next_state   = ST_SETUP_A;
        end
      end
      ST_SETUP_A, ST_SETUP_B: begin
        if (expire) begin
          tmr_load     = 1'b1;
          tmr_load_val = PRESS_LD;
          next_state   = (state == ST_SETUP_A) ? ST_PRESS_A : ST_PRESS_B;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_PRESS_A, ST_PRESS_B: begin
        if (expire) begin
          next_state = (state == ST_PRESS_A) ? ST_REL_A : ST_REL_B;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_REL_A: begin
        tmr_load     = 1'b1;
        tmr_load_val = SETUP_LD;
        next_state   = ST_SETUP_B;
      end
      ST_REL_B: begin
        tmr_load     = 1'b1;
        tmr_load_val = WAIT_LD;
        next_state   = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (ResultValid) begin
          capture    = 1'b1;
          next_state = ST_DONE;
        end else if (expire) begin
          capture    = 1'b1;
          capture_to = 1'b1;
          next_state = ST_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Output flop inputs follow the state being entered, so outputs align with state.
  always_comb begin
    go_d   = (next_state == ST_PRESS_A) || (next_state == ST_PRESS_B);
    busy_d = (next_state != ST_IDLE) && (next_state != ST_DONE);
    done_d = (next_state == ST_DONE);
    data_d = DataOut;
    case (next_state)
      ST_SETUP_A, ST_PRESS_A, ST_REL_A: data_d = (state == ST_IDLE) ? OpA : op_a;
      ST_SETUP_B, ST_PRESS_B, ST_REL_B: data_d = op_b;
      default:                          data_d = DataOut;
    endcase
  end

  // State, operand latches, registered outputs and result capture.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= ST_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      Go      <= 1'b0;
      DataOut <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Result  <= '0;
      Timeout <= 1'b0;
    end else begin
      state   <= next_state;
      Go      <= go_d;
      DataOut <= data_d;
      Busy    <= busy_d;
      Done    <= done_d;
      if (latch_ops) begin
        op_a <= OpA;
        op_b <= OpB;
      end
      if (capture) begin
        Result  <= DataResult;
        Timeout <= capture_to;
      end
    end
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Bench for operand_feeder: the driver plays both the requester and an
// a*a+b arithmetic unit, predicting every Go pulse and every Done from the
// cycle-level timeline of a transaction; monitors compare as outputs appear.
module tb_operand_feeder;
  import feeder_pkg::*;

  localparam int S = SETUP_CYCLES_DEF;
  localparam int P = PRESS_CYCLES_DEF;
  localparam int W = RESULT_WAIT_DEF;

  logic       Clock, Resetn, Start, Go, ResultValid, Busy, Done, Timeout;
  logic [7:0] OpA, OpB, DataOut, DataResult, Result;
  logic [3:0] state_dbg;

  int cyc    = 0;
  int n_vec  = 0;
  int n_fail = 0;

  // Go pulse item: {data[55:48], rise cycle[47:16], width[15:0]}
  logic [55:0] exp_go_q[$];
  // Done item: {result[40:33], timeout[32], done cycle[31:0]}
  logic [40:0] exp_res_q[$];

  operand_feeder #(
    .SETUP_CYCLES (S),
    .PRESS_CYCLES (P),
    .RESULT_WAIT  (W)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Start       (Start),
    .OpA         (OpA),
    .OpB         (OpB),
    .Go          (Go),
    .DataOut     (DataOut),
    .DataResult  (DataResult),
    .ResultValid (ResultValid),
    .Busy        (Busy),
    .Done        (Done),
    .Result      (Result),
    .Timeout     (Timeout),
    .state_dbg   (state_dbg)
  );

  // Clock and cycle counter
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: Go pulses, Done events and held result
  logic       prev_go  = 1'b0;
  logic [7:0] cur_data = '0;
  int         rise_at  = 0;
  int         cur_w    = 0;
  logic [7:0] held_res = '0;
  logic       held_to  = 1'b0;

  always @(negedge Clock) begin
    logic [55:0] gi;
    logic [40:0] ri;
    if (!Resetn) begin
      prev_go  <= 1'b0;
      held_res <= '0;
      held_to  <= 1'b0;
    end else begin
      if (Go && !prev_go) begin
        if (exp_go_q.size() == 0) begin
          chk("go_unexpected", 32'(Go), 32'd0);
        end else begin
          gi = exp_go_q.pop_front();
          chk("go_data", 32'(DataOut), 32'(gi[55:48]));
          chk("go_rise_cycle", 32'(cyc), gi[47:16]);
          cur_data <= gi[55:48];
          cur_w    <= int'(gi[15:0]);
          rise_at  <= cyc;
        end
      end else if (Go && prev_go) begin
        chk("go_data_stable", 32'(DataOut), 32'(cur_data));
      end else if (!Go && prev_go) begin
        chk("go_width", 32'(cyc - rise_at), 32'(cur_w));
      end
      if (Go) chk("busy_during_go", 32'(Busy), 32'd1);
      if (Done) begin
        chk("busy_at_done", 32'(Busy), 32'd0);
        if (exp_res_q.size() == 0) begin
          chk("done_unexpected", 32'(Done), 32'd0);
        end else begin
          ri = exp_res_q.pop_front();
          chk("result", 32'(Result), 32'(ri[40:33]));
          chk("timeout", 32'(Timeout), 32'(ri[32]));
          chk("done_cycle", 32'(cyc), ri[31:0]);
          held_res <= ri[40:33];
          held_to  <= ri[32];
        end
      end else begin
        chk("result_hold", 32'(Result), 32'(held_res));
        chk("timeout_hold", 32'(Timeout), 32'(held_to));
      end
      prev_go <= Go;
    end
  end

  // One transaction. d < W: ResultValid in WAIT_RES cycle d; d == W: no
  // response, so the value on DataResult at expiry (to_val) is captured.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int d,
                         input bit hold, input bit rv_junk, input int gap,
                         input logic [7:0] to_val);
    int         c0, cw, cd, prod;
    logic [7:0] val, er;
    logic       et;
    @(negedge Clock);
    if (gap > 0) begin
      Start = 1'b0;
      repeat (gap) @(negedge Clock);
    end
    chk("busy_idle", 32'(Busy), 32'd0);
    prod = int'(a) * int'(a) + int'(b);
    val  = prod[7:0];
    c0   = cyc + 1;
    cw   = c0 + 2 * (S + P + 1);
    if (d < W) begin
      cd = cw + d + 1; er = val;    et = 1'b0;
    end else begin
      cd = cw + W;     er = to_val; et = 1'b1;
    end
    exp_go_q.push_back({a, 32'(c0 + S), 16'(P)});
    exp_go_q.push_back({b, 32'(c0 + 2 * S + P + 1), 16'(P)});
    exp_res_q.push_back({er, et, 32'(cd)});
    Start = 1'b1;
    OpA   = a;
    OpB   = b;
    while (cyc < cd) begin
      @(negedge Clock);
      Start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      OpA   = 8'($urandom);
      OpB   = 8'($urandom);
      if (cyc >= cw && cyc < cd) begin
        if (d < W && cyc == cw + d) begin
          ResultValid = 1'b1; DataResult = val;
        end else begin
          ResultValid = 1'b0; DataResult = to_val;
        end
      end else begin
        ResultValid = rv_junk ? 1'($urandom_range(0, 1)) : 1'b0;
        DataResult  = 8'($urandom);
      end
      chk("busy", 32'(Busy), (cyc < cd) ? 32'd1 : 32'd0);
    end
  endtask

  // Start a transaction and pull reset during the first PRESS_B cycle.
  task automatic abort_in_press_b(input logic [7:0] a, input logic [7:0] b);
    int c0;
    @(negedge Clock);
    chk("busy_idle", 32'(Busy), 32'd0);
    c0 = cyc + 1;
    exp_go_q.push_back({a, 32'(c0 + S), 16'(P)});
    exp_go_q.push_back({b, 32'(c0 + 2 * S + P + 1), 16'(P)});
    Start = 1'b1;
    OpA   = a;
    OpB   = b;
    while (cyc < c0 + 2 * S + P + 1) begin
      @(negedge Clock);
      Start       = 1'($urandom_range(0, 1));
      OpA         = 8'($urandom);
      OpB         = 8'($urandom);
      ResultValid = 1'b0;
    end
    #1;
    Resetn = 1'b0;
    exp_go_q.delete();
    exp_res_q.delete();
    #1;
    chk("rst_go", 32'(Go), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_dataout", 32'(DataOut), 32'd0);
    chk("rst_result", 32'(Result), 32'd0);
    Start = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  // Main sequence
  initial begin
    Resetn = 1'b0; Start = 1'b0; OpA = '0; OpB = '0;
    DataResult = '0; ResultValid = 1'b0;
    repeat (3) @(negedge Clock);
    chk("reset_go", 32'(Go), 32'd0);
    chk("reset_dataout", 32'(DataOut), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_done", 32'(Done), 32'd0);
    chk("reset_result", 32'(Result), 32'd0);
    chk("reset_timeout", 32'(Timeout), 32'd0);
    Resetn = 1'b1;

    // 3 then 5, unit answers 3*3+5 = 14 after one wait cycle
    run_txn(8'd3, 8'd5, 1, 1'b0, 1'b0, 1, 8'h00);
    // No response: capture 8'h2A on expiry with Timeout
    run_txn(8'h10, 8'h20, W, 1'b0, 1'b0, 2, 8'h2A);
    // Spurious ResultValid before WAIT_RES; 4*4+2 = 18
    run_txn(8'd4, 8'd2, 2, 1'b0, 1'b1, 0, 8'h00);
    // Start held high: one transaction per IDLE visit
    for (int i = 0; i < 3; i++)
      run_txn(8'd1, 8'd2, $urandom_range(0, W), 1'b1, 1'b0, 0, 8'($urandom));
    // Reset during PRESS_B, then a clean 7*7+1 = 50
    abort_in_press_b(8'h55, 8'hAA);
    run_txn(8'd7, 8'd1, 0, 1'b0, 1'b0, 1, 8'h00);
    // Randomized transactions
    for (int i = 0; i < 30; i++)
      run_txn(8'($urandom), 8'($urandom), $urandom_range(0, W), 1'b0,
              1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom));

    repeat (5) @(negedge Clock);
    chk("pending_done", 32'(exp_res_q.size()), 32'd0);
    chk("pending_go", 32'(exp_go_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2: cycles DataOut is held stable with Go low before each press (minimum 1).
REQ-002 SHALL have parameter PRESS_CYCLES, default 2: cycles Go is held high per operand (minimum 1).
REQ-003 SHALL have parameter RESULT_WAIT, default 4: maximum cycles to wait for ResultValid after the last release (minimum 1).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: Clock  input  1  rising-edge clock.
REQ-005 Resetn  input  1  asynchronous active-low reset.
REQ-006 Start  input  1  one-cycle request to run one transaction.
REQ-007 OpA  input  8  first operand, captured at accepted Start.
REQ-008 OpB  input  8  second operand, captured at accepted Start.
REQ-009 Go  output  1  registered go strobe to the arithmetic unit.
REQ-010 DataOut  output  8  registered operand bus to the arithmetic unit.
REQ-011 DataResult  input  8  result bus from the arithmetic unit.
REQ-012 ResultValid  input  1  result-valid flag from the arithmetic unit.
REQ-013 Busy  output  1  high from accepted Start until Done.
REQ-014 Done  output  1  one-cycle pulse when Result is updated.
REQ-015 Result  output  8  captured result, held until next Done.
REQ-016 Timeout  output  1  high with Done when capture came from RESULT_WAIT expiry, not ResultValid.

Function
REQ-017 SHALL implement states IDLE, SETUP_A, PRESS_A, REL_A, SETUP_B, PRESS_B, REL_B, WAIT_RES, DONE, one state register, and one down-counter shared across timed states.
REQ-018 IDLE: Start=1 SHALL latch OpA/OpB into internal registers, load counter with SETUP_CYCLES, and enter SETUP_A next edge; Start in any other state SHALL be ignored.
REQ-019 SETUP_A: DataOut=latched A, Go=0 for SETUP_CYCLES cycles, then PRESS_A.
REQ-020 PRESS_A: DataOut=A, Go=1 for PRESS_CYCLES cycles, then REL_A; DataOut SHALL NOT change while Go=1.
REQ-021 REL_A: Go=0, DataOut=A for exactly 1 cycle, then SETUP_B.
REQ-022 SETUP_B/PRESS_B/REL_B SHALL mirror REQ-019..021 with latched B; REL_B then enters WAIT_RES with counter loaded to RESULT_WAIT.
REQ-023 WAIT_RES: Go=0; ResultValid=1 SHALL capture DataResult into Result, clear Timeout, enter DONE; else counter expiry SHALL capture DataResult, set Timeout, enter DONE.
REQ-024 ResultValid sampled in any state other than WAIT_RES SHALL be ignored.
REQ-025 DONE: Done=1, Busy=0 for exactly 1 cycle, then IDLE; Start in DONE SHALL be ignored.
REQ-026 Go and DataOut SHALL be flop outputs with no combinational path from any input.
REQ-027 Per transaction: Go SHALL rise exactly twice, first carrying A, then B; total latency Start to Done = 2*(SETUP_CYCLES+PRESS_CYCLES+1) + (cycles in WAIT_RES) + 2.
REQ-028 Counter SHALL be wide enough for max(SETUP_CYCLES, PRESS_CYCLES, RESULT_WAIT) and SHALL never wrap.

Reset
REQ-029 Resetn=0 SHALL force, asynchronously: state IDLE, Go=0, DataOut=0, Busy=0, Done=0, Result=0, Timeout=0, counter=0, latched operands=0.
REQ-030 Reset mid-transaction SHALL abort with no Done pulse; first Start after Resetn rises SHALL be accepted normally.

Structure
REQ-031 State encodings and parameter defaults SHALL live in a shared package feeder_pkg.
REQ-032 SHALL be a single module; optional sub-module feeder_timer (load/decrement/zero-flag counter) is permitted.

Verification
REQ-033 Defaults, Start with OpA=3, OpB=5, receiver returns 14 with ResultValid -> Go pulses carry 3 then 5, each 2 cycles wide after 2 setup cycles; Done once, Result=14, Timeout=0.
REQ-034 ResultValid tied 0, DataResult=8'h2A -> Done exactly 4 cycles after entering WAIT_RES, Result=8'h2A, Timeout=1.
REQ-035 Start held high 40 cycles with OpA=1, OpB=2 -> exactly one transaction per IDLE visit; operands changed during Busy do not alter DataOut.
REQ-036 Resetn pulsed low during PRESS_B -> Go=0, Busy=0 immediately, no Done; next Start with OpA=7, OpB=1 completes correctly.
REQ-037 ResultValid=1 during PRESS_A -> ignored; Result taken only in WAIT_RES.
REQ-038 End-to-end with the a^2+b arithmetic unit, OpA=4, OpB=2 -> Result=18.
